coffee_machine_controller: RTL and testbench

//  Top-level sequencer for the coffee vending datapath. Accumulates inserted coins and

---
 rtl/coffee_pkg.sv | 21 ++
 rtl/brew_timer.sv | 29 ++
 rtl/coffee_machine_controller.sv | 128 ++++++++++++
 tb/tb_coffee_machine_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee machine controller slice.
package coffee_pkg;

   localparam int COIN_W = 4;
   localparam int TYPE_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      CHECK,
      BREW,
      DISPENSE,
      DONE
   } state_t;

   localparam logic [TYPE_W-1:0] EXPRESSO    = 3'd0;
   localparam logic [TYPE_W-1:0] COFFEE_MILK = 3'd1;
   localparam logic [TYPE_W-1:0] CAPUCCINO   = 3'd2;
   localparam logic [TYPE_W-1:0] MOCACCINO   = 3'd3;

endpackage

// File: rtl/brew_timer.sv
// Brew duration counter: cleared by load, advances while run, flags the last brew cycle.
module brew_timer #(
   parameter int BREW_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = $clog2(BREW_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // expired is high during the final cycle so the controller can drop brewing on that edge
   assign expired = (cnt == CNT_W'(BREW_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (run && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/coffee_machine_controller.sv
// Coin collection, drink check against the external subtractor, brew timing and change payout.
module coffee_machine_controller
   import coffee_pkg::*;
#(
   parameter int BREW_CYCLES = 8,
   parameter int MAX_COINS   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              coin_in,
   input  logic              sel_valid,
   input  logic [TYPE_W-1:0] sel_type,
   input  logic              cancel,
   output logic [TYPE_W-1:0] sub_coffee_type,
   output logic [COIN_W-1:0] sub_total_coins,
   input  logic [COIN_W-1:0] sub_change,
   input  logic              sub_enable_timer,
   output logic              brewing,
   output logic              coin_out,
   output logic              coin_reject,
   output logic              insufficient,
   output logic              done,
   output state_t            dbg_state
);

   localparam logic [COIN_W-1:0] MAX_ACC = COIN_W'(MAX_COINS);

   state_t            state;
   logic [COIN_W-1:0] acc;
   logic [COIN_W-1:0] change_reg;
   logic [TYPE_W-1:0] sel_reg;
   logic              timer_expired;

   assign sub_coffee_type = sel_reg;
   assign sub_total_coins = acc;
   assign dbg_state       = state;

   brew_timer #(
      .BREW_CYCLES(BREW_CYCLES)
   ) u_brew_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state == CHECK),
      .run    (state == BREW),
      .expired(timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         change_reg   <= '0;
         sel_reg      <= EXPRESSO;
         brewing      <= 1'b0;
         coin_out     <= 1'b0;
         coin_reject  <= 1'b0;
         insufficient <= 1'b0;
         done         <= 1'b0;
      end else begin
         coin_out     <= 1'b0;
         coin_reject  <= 1'b0;
         insufficient <= 1'b0;
         done         <= 1'b0;
         case (state)
            IDLE: begin
               if (coin_in) begin
                  acc   <= COIN_W'(1);
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               // cancel wins; a coin arriving with it is bounced, not refunded
               if (cancel) begin
                  change_reg  <= acc;
                  acc         <= '0;
                  coin_reject <= coin_in;
                  state       <= DISPENSE;
               end else begin
                  if (coin_in) begin
                     if (acc == MAX_ACC) coin_reject <= 1'b1;
                     else                acc         <= acc + 1'b1;
                  end
                  if (sel_valid) begin
                     sel_reg <= sel_type;
                     state   <= CHECK;
                  end
               end
            end
            CHECK: begin
               coin_reject <= coin_in;
               // unknown drink codes never brew, whatever the subtractor says
               if (sub_enable_timer && (sel_reg <= MOCACCINO)) begin
                  change_reg <= sub_change;
                  acc        <= '0;
                  brewing    <= 1'b1;
                  state      <= BREW;
               end else begin
                  insufficient <= 1'b1;
                  state        <= COLLECT;
               end
            end
            BREW: begin
               coin_reject <= coin_in;
               if (timer_expired) begin
                  brewing <= 1'b0;
                  state   <= DISPENSE;
               end
            end
            DISPENSE: begin
               coin_reject <= coin_in;
               if (change_reg != '0) begin
                  coin_out   <= 1'b1;
                  change_reg <= change_reg - 1'b1;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               coin_reject <= coin_in;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coffee_machine_controller.sv
// Transaction-level bench: predicts pulse counts and brew timing per purchase from prices and coin arithmetic.
module tb_coffee_machine_controller;
   import coffee_pkg::*;

   localparam int BREW_CYCLES = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              coin_in = 1'b0;
   logic              sel_valid = 1'b0;
   logic [TYPE_W-1:0] sel_type = '0;
   logic              cancel = 1'b0;
   logic [TYPE_W-1:0] sub_coffee_type;
   logic [COIN_W-1:0] sub_total_coins;
   logic [COIN_W-1:0] sub_change;
   logic              sub_enable_timer;
   logic              brewing, coin_out, coin_reject, insufficient, done;
   state_t            dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int tot_out = 0, tot_rej = 0, tot_ins = 0, tot_done = 0, tot_brew = 0;
   int brew_rise = -1;
   logic prev_brew = 1'b0;
   logic [15:0] exp_q[$];

   coffee_machine_controller #(
      .BREW_CYCLES(BREW_CYCLES),
      .MAX_COINS  (15)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .coin_in         (coin_in),
      .sel_valid       (sel_valid),
      .sel_type        (sel_type),
      .cancel          (cancel),
      .sub_coffee_type (sub_coffee_type),
      .sub_total_coins (sub_total_coins),
      .sub_change      (sub_change),
      .sub_enable_timer(sub_enable_timer),
      .brewing         (brewing),
      .coin_out        (coin_out),
      .coin_reject     (coin_reject),
      .insufficient    (insufficient),
      .done            (done),
      .dbg_state       (dbg_state)
   );

   // clock/reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int price_of(input int t);
      case (t)
         0:       return 3;
         1:       return 4;
         2:       return 5;
         3:       return 7;
         default: return 99;
      endcase
   endfunction

   // stand-in for the price/change subtractor that sits beside the controller
   always_comb begin
      sub_change       = '0;
      sub_enable_timer = 1'b0;
      if (int'(sub_coffee_type) <= 3 && int'(sub_total_coins) >= price_of(int'(sub_coffee_type))) begin
         sub_enable_timer = 1'b1;
         sub_change       = COIN_W'(int'(sub_total_coins) - price_of(int'(sub_coffee_type)));
      end
   end

   // output monitor: running totals of every pulse and the last brewing rise
   always @(negedge clk) begin
      if (coin_out)     tot_out++;
      if (coin_reject)  tot_rej++;
      if (insufficient) tot_ins++;
      if (done)         tot_done++;
      if (brewing)      tot_brew++;
      if (brewing && !prev_brew) brew_rise = cyc;
      prev_brew = brewing;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic add_coins(input int n, inout int acc, inout int rej);
      for (int i = 0; i < n; i++) begin
         coin_in = 1'b1;
         @(negedge clk);
         coin_in = 1'b0;
         if (acc < 15) acc++;
         else          rej++;
      end
      check_eq("acc", int'(sub_total_coins), acc);
   endtask

   task automatic do_select(input int typ, input int acc, output bit ok, output int sel_cyc);
      ok        = (typ <= 3) && (acc >= price_of(typ));
      sel_valid = 1'b1;
      sel_type  = TYPE_W'(typ);
      sel_cyc   = cyc;
      @(negedge clk);
      sel_valid = 1'b0;
      check_eq("latched_type", int'(sub_coffee_type), typ);
      @(negedge clk);
      check_eq("insufficient", int'(insufficient), int'(!ok));
      check_eq("brew_start", int'(brewing), int'(ok));
   endtask

   // mode 0: select (top-up and reselect once if short), then a cancel that only lands if not brewing
   // mode 1: cancel; mode 2: cancel with a coin in the same cycle
   task automatic run_txn(input int n, input int mode, input int typ, input int top_up, input bit brew_coin);
      int acc, rej, ins, out, brew, sel_cyc;
      int b_out, b_rej, b_ins, b_done, b_brew;
      bit ok;
      b_out = tot_out; b_rej = tot_rej; b_ins = tot_ins; b_done = tot_done; b_brew = tot_brew;
      acc = 0; rej = 0; ins = 0; ok = 1'b0; sel_cyc = 0;
      add_coins(n, acc, rej);
      if (mode == 0) begin
         do_select(typ, acc, ok, sel_cyc);
         if (!ok) ins++;
         if (!ok && top_up > 0) begin
            add_coins(top_up, acc, rej);
            do_select(typ, acc, ok, sel_cyc);
            if (!ok) ins++;
         end
         cancel = 1'b1;
         @(negedge clk);
         cancel = 1'b0;
         if (brew_coin) begin
            coin_in = 1'b1;
            @(negedge clk);
            coin_in = 1'b0;
            rej++;
         end
         out  = ok ? acc - price_of(typ) : acc;
         brew = ok ? BREW_CYCLES : 0;
      end else begin
         cancel  = 1'b1;
         coin_in = (mode == 2);
         @(negedge clk);
         cancel  = 1'b0;
         coin_in = 1'b0;
         if (mode == 2) rej++;
         out  = acc;
         brew = 0;
      end
      exp_q.push_back(16'(out));
      exp_q.push_back(16'(rej));
      exp_q.push_back(16'(ins));
      exp_q.push_back(16'(brew));
      exp_q.push_back(16'd1);
      for (int i = 0; i < 300; i++) begin
         if (tot_done > b_done) break;
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      check_eq("coin_out_count", tot_out - b_out, int'(exp_q.pop_front()));
      check_eq("reject_count", tot_rej - b_rej, int'(exp_q.pop_front()));
      check_eq("insufficient_count", tot_ins - b_ins, int'(exp_q.pop_front()));
      check_eq("brew_cycles", tot_brew - b_brew, int'(exp_q.pop_front()));
      check_eq("done_count", tot_done - b_done, int'(exp_q.pop_front()));
      if (ok) check_eq("brew_rise_cycle", brew_rise, sel_cyc + 2);
      check_eq("idle_after", int'(dbg_state == IDLE), 1);
   endtask

   task automatic reset_mid_brew();
      int acc, rej, sel_cyc, b_out, b_done;
      bit ok;
      acc = 0; rej = 0;
      add_coins(5, acc, rej);
      do_select(1, acc, ok, sel_cyc);
      @(negedge clk);
      @(negedge clk);
      check_eq("brewing_before_reset", int'(brewing), 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_brewing", int'(brewing), 0);
      check_eq("rst_outputs", int'({coin_out, coin_reject, insufficient, done}), 0);
      check_eq("rst_acc", int'(sub_total_coins), 0);
      check_eq("rst_state", int'(dbg_state == IDLE), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      b_out  = tot_out;
      b_done = tot_done;
      repeat (20) @(negedge clk);
      check_eq("no_payout_after_reset", tot_out - b_out, 0);
      check_eq("no_done_after_reset", tot_done - b_done, 0);
      check_eq("idle_after_reset", int'(dbg_state == IDLE), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", int'({brewing, coin_out, coin_reject, insufficient, done}), 0);
      check_eq("reset_acc", int'(sub_total_coins), 0);
      check_eq("reset_type", int'(sub_coffee_type), 0);
      check_eq("reset_state", int'(dbg_state == IDLE), 1);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(3, 0, 0, 0, 1'b0);
      run_txn(9, 0, 3, 0, 1'b0);
      run_txn(2, 0, 2, 3, 1'b0);
      run_txn(5, 1, 0, 0, 1'b0);
      run_txn(4, 2, 0, 0, 1'b0);
      run_txn(16, 1, 0, 0, 1'b0);
      run_txn(6, 0, 1, 0, 1'b1);
      run_txn(10, 0, 6, 0, 1'b0);
      reset_mid_brew();

      for (int t = 0; t < 30; t++) begin
         int r, mode;
         r    = int'($urandom_range(0, 9));
         mode = (r <= 6) ? 0 : (r <= 8) ? 1 : 2;
         run_txn(int'($urandom_range(1, 17)), mode, int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
